// File: rtl/and_test_pkg.sv
// Shared types and constants for the AND-gate board self-test sequencer.
package and_test_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned STEP_W  = 2;
  localparam int unsigned NUM_VEC = 4;

  // Expected gate output indexed by step (step[1]=in1, step[0]=in2).
  localparam logic [NUM_VEC-1:0] AND_TRUTH = 4'b1000;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: runs 0..DWELL_CYCLES-1 while enabled and flags the terminal count.
module dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 25_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_last
);

  localparam int unsigned CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Terminal-count compare on the registered count.
  assign o_last = (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = o_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/and_gate_self_test.sv
// Self-test sequencer: walks the four input vectors through the AND gate,
// holds each for DWELL_CYCLES and latches per-vector mismatch flags.
module and_gate_self_test
  import and_test_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 25_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_dut_out,
  output logic               o_dut_in1,
  output logic               o_dut_in2,
  output logic [STEP_W-1:0]  o_step,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [NUM_VEC-1:0] o_fail_vec
);

  state_t               state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [NUM_VEC-1:0]   fail_vec_q, fail_vec_d;
  logic                 dut_in1_q, dut_in1_d;
  logic                 dut_in2_q, dut_in2_d;
  logic                 start_q, start_d;
  logic                 start_edge;
  logic                 tmr_clear;
  logic                 tmr_en;
  logic                 tmr_last;

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (tmr_clear),
    .i_en    (tmr_en),
    .o_last  (tmr_last)
  );

  assign start_edge = i_start & ~start_q;
  assign start_d    = i_start;

  // Next-state, step and result logic; gate inputs follow step_d so they
  // change in the same cycle the step register does.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_vec_d = fail_vec_q;
    dut_in1_d  = dut_in1_q;
    dut_in2_d  = dut_in2_q;
    tmr_clear  = 1'b0;
    tmr_en     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        tmr_clear = 1'b1;
        if (start_edge) begin
          state_d    = APPLY;
          step_d     = '0;
          fail_vec_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          dut_in1_d  = 1'b0;
          dut_in2_d  = 1'b0;
        end
      end
      APPLY: begin
        tmr_en = 1'b1;
        if (tmr_last) begin
          if (i_dut_out != AND_TRUTH[step_q]) begin
            fail_vec_d[step_q] = 1'b1;
          end
          if (step_q == STEP_W'(NUM_VEC - 1)) begin
            state_d   = DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = (fail_vec_d == '0);
            step_d    = '0;
            dut_in1_d = 1'b0;
            dut_in2_d = 1'b0;
          end else begin
            step_d    = step_q + STEP_W'(1);
            dut_in1_d = step_d[1];
            dut_in2_d = step_d[0];
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      step_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_vec_q <= '0;
      dut_in1_q  <= 1'b0;
      dut_in2_q  <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_vec_q <= fail_vec_d;
      dut_in1_q  <= dut_in1_d;
      dut_in2_q  <= dut_in2_d;
      start_q    <= start_d;
    end
  end

  assign o_dut_in1  = dut_in1_q;
  assign o_dut_in2  = dut_in2_q;
  assign o_step     = step_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_pass     = pass_q;
  assign o_fail_vec = fail_vec_q;

endmodule

// File: tb/tb_and_gate_self_test.sv
// Bench for and_gate_self_test with DWELL_CYCLES=4 and a selectable gate model.
module tb_and_gate_self_test;

  localparam int unsigned DWELL = 4;
  localparam int unsigned RUN_CYCLES = 4 * DWELL + 1;

  localparam int MODE_AND = 0;
  localparam int MODE_OR  = 1;
  localparam int MODE_SA0 = 2;
  localparam int MODE_SA1 = 3;

  localparam int START_PULSE   = 0;
  localparam int START_HOLD    = 1;
  localparam int START_REPULSE = 2;

  typedef struct packed {
    logic [3:0] fail_vec;
    logic       pass;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       dut_out;
  logic       dut_in1;
  logic       dut_in2;
  logic [1:0] step;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;

  int   gate_mode;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  and_gate_self_test #(
    .DWELL_CYCLES(DWELL)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_dut_out  (dut_out),
    .o_dut_in1  (dut_in1),
    .o_dut_in2  (dut_in2),
    .o_step     (step),
    .o_busy     (busy),
    .o_done     (done),
    .o_pass     (pass),
    .o_fail_vec (fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic gate_model(input int mode, input logic a, input logic b);
    case (mode)
      MODE_OR:  return a | b;
      MODE_SA0: return 1'b0;
      MODE_SA1: return 1'b1;
      default:  return a & b;
    endcase
  endfunction

  assign dut_out = gate_model(gate_mode, dut_in1, dut_in2);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] all_outs();
    return {dut_in1, dut_in2, step, busy, done, pass, fail_vec};
  endfunction

  // Expected results derived from the gate model and the ideal AND table.
  function automatic exp_t expect_for(input int mode);
    exp_t e;
    e.fail_vec = '0;
    for (int k = 0; k < 4; k++) begin
      logic a, b;
      a = ((k >> 1) & 1) != 0;
      b = (k & 1) != 0;
      if (gate_model(mode, a, b) != (a & b)) e.fail_vec[k] = 1'b1;
    end
    e.pass = (e.fail_vec == '0);
    return e;
  endfunction

  // One run: start edge in cycle N, cycle-by-cycle checks through N+17.
  // abort_at > 0 asserts reset after that cycle's checks.
  task automatic do_run(input int mode, input int start_mode, input int abort_at);
    exp_t e;
    int   s;
    gate_mode = mode;
    sb_q.push_back(expect_for(mode));
    start = 1'b1;
    for (int c = 1; c <= int'(RUN_CYCLES); c++) begin
      @(negedge clk);
      if (start_mode != START_HOLD && c == 1) start = 1'b0;
      if (start_mode == START_REPULSE && c == 6) start = 1'b1;
      if (start_mode == START_REPULSE && c == 7) start = 1'b0;
      if (c < int'(RUN_CYCLES)) begin
        s = (c - 1) / int'(DWELL);
        check_eq($sformatf("busy@%0d", c), 32'(busy), 32'd1);
        check_eq($sformatf("done@%0d", c), 32'(done), 32'd0);
        check_eq($sformatf("pass@%0d", c), 32'(pass), 32'd0);
        check_eq($sformatf("step@%0d", c), 32'(step), 32'(s));
        check_eq($sformatf("in@%0d", c), 32'({dut_in1, dut_in2}), 32'(s));
        if (c == 1) check_eq("fail_vec_clear", 32'(fail_vec), 32'd0);
      end else begin
        if (sb_q.size() == 0) begin
          check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("done_final", 32'(done), 32'd1);
          check_eq("busy_final", 32'(busy), 32'd0);
          check_eq("pass_final", 32'(pass), 32'(e.pass));
          check_eq("fail_vec_final", 32'(fail_vec), 32'(e.fail_vec));
          check_eq("step_in_final", 32'({step, dut_in1, dut_in2}), 32'd0);
        end
      end
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_outs", 32'(all_outs()), 32'd0);
        rst = 1'b0;
        sb_q.delete();
        return;
      end
    end
  endtask

  // Hold in DONE with i_start static: nothing may retrigger.
  task automatic check_held_done(input exp_t e, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_eq("held_busy", 32'(busy), 32'd0);
      check_eq("held_done", 32'(done), 32'd1);
      check_eq("held_fail_vec", 32'(fail_vec), 32'(e.fail_vec));
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    gate_mode = MODE_AND;
    rst       = 1'b1;
    start     = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq($sformatf("reset_idle@%0d", i), 32'(all_outs()), 32'd0);
    end

    do_run(MODE_AND, START_PULSE, 0);
    check_held_done(expect_for(MODE_AND), 3);
    do_run(MODE_OR, START_PULSE, 0);
    check_held_done(expect_for(MODE_OR), 2);
    do_run(MODE_SA0, START_PULSE, 0);
    check_held_done(expect_for(MODE_SA0), 2);
    do_run(MODE_SA1, START_PULSE, 0);
    check_held_done(expect_for(MODE_SA1), 2);

    // Level held through and past the run: single run only.
    do_run(MODE_AND, START_HOLD, 0);
    check_held_done(expect_for(MODE_AND), 5);
    start = 1'b0;
    check_held_done(expect_for(MODE_AND), 2);

    // Stuck-at-1 leaves failing results in DONE; a new edge must clear them.
    do_run(MODE_SA1, START_REPULSE, 0);
    check_held_done(expect_for(MODE_SA1), 2);
    do_run(MODE_AND, START_PULSE, 0);
    check_held_done(expect_for(MODE_AND), 2);

    // Reset during step 2, then a clean run from step 0.
    do_run(MODE_AND, START_PULSE, 10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_abort_idle", 32'(all_outs()), 32'd0);
    end
    do_run(MODE_AND, START_PULSE, 0);
    check_held_done(expect_for(MODE_AND), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
